// File: rtl/magic_buttons.sv
// Debounced, frame-stretched magic/pause button conditioning for the NMI logic.
// Optional long-press reboot detector compiled in by defining LONG_PRESS_EN.
module magic_buttons #(
    parameter int TICK_DIV      = 28000,
    parameter int DEBOUNCE_MS   = 16,
    parameter int LONG_PRESS_MS = 2000
) (
    input  logic clk28,
    input  logic rst_n,
    input  logic n_magic_raw,
    input  logic n_pause_raw,
    input  logic n_int,
    input  logic n_int_next,
    output logic magic_button,
    output logic pause_button,
    output logic long_press
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_MS + 1);

    typedef enum logic [1:0] {IDLE, HELD, SEEN, PENDING} btn_state_t;

    // Index 0 is the magic button, index 1 the pause button; levels are low = pressed.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [DW-1:0] deb_cnt [2];
    btn_state_t    state [2];
    btn_state_t    state_next [2];
    logic [1:0]    btn_q;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          frame_edge;

    assign raw        = {n_pause_raw, n_magic_raw};
    assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
    assign frame_edge = n_int & ~n_int_next;

    // NOTE: every flop here, including the small per-button arrays, takes the
    // synchronous reset so a reset mid-press fully discards the press.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            sync1    <= '1;
            sync2    <= '1;
            deb      <= '1;
            btn_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
                state[i]   <= IDLE;
            end
        end else begin
            // NOTE: non-blocking assignments make every flop see pre-edge values.
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            sync1    <= raw;
            sync2    <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (tick) begin
                    if (deb_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                        deb[i]     <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end
                state[i] <= state_next[i];
                btn_q[i] <= (state_next[i] != IDLE);
            end
        end
    end

    // A press that never spans a frame edge is held in PENDING until one arrives.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: default first so no branch leaves state_next unassigned (no latch).
            state_next[i] = state[i];
            case (state[i])
                IDLE:    if (!deb[i])   state_next[i] = HELD;
                HELD: begin
                    if (frame_edge)     state_next[i] = SEEN;
                    else if (deb[i])    state_next[i] = PENDING;
                end
                SEEN:    if (deb[i])    state_next[i] = IDLE;
                PENDING: if (frame_edge) state_next[i] = IDLE;
                default:                state_next[i] = IDLE;
            endcase
        end
    end

    assign magic_button = btn_q[0];
    assign pause_button = btn_q[1];

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_MS + 1);

    logic [HW-1:0] hold_cnt;
    logic          long_q;

    // Saturating at LONG_PRESS_MS guarantees a single pulse per press.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            long_q   <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (deb[0]) begin
                hold_cnt <= '0;
            end else if (tick && (hold_cnt != HW'(LONG_PRESS_MS))) begin
                hold_cnt <= hold_cnt + 1'b1;
                long_q   <= (hold_cnt == HW'(LONG_PRESS_MS - 1));
            end
        end
    end

    assign long_press = long_q;
`else
    // Keeps the parameter referenced when the detector is compiled out.
    logic unused_long_press_ms;
    assign unused_long_press_ms = ^32'(LONG_PRESS_MS);
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_magic_buttons.sv
// Directed self-checking bench for magic_buttons (TICK_DIV=4, DEBOUNCE_MS=3,
// LONG_PRESS_MS=10); long-press expectations follow the LONG_PRESS_EN macro.
module tb_magic_buttons;

    logic clk28 = 1'b0;
    logic rst_n;
    logic n_magic_raw;
    logic n_pause_raw;
    logic n_int;
    logic n_int_next;
    logic magic_button;
    logic pause_button;
    logic long_press;

    int checks   = 0;
    int failures = 0;

    magic_buttons #(
        .TICK_DIV      (4),
        .DEBOUNCE_MS   (3),
        .LONG_PRESS_MS (10)
    ) dut (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .n_magic_raw  (n_magic_raw),
        .n_pause_raw  (n_pause_raw),
        .n_int        (n_int),
        .n_int_next   (n_int_next),
        .magic_button (magic_button),
        .pause_button (pause_button),
        .long_press   (long_press)
    );

    always #5 clk28 = ~clk28;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Counts posedges (first edge after the call is 1) until the selected output
    // reaches lvl; returns -1 if it does not within limit cycles.
    task automatic wait_level(input int which, input logic lvl, input int limit, output int n);
        logic obs;
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk28);
            #1;
            obs = (which == 0) ? magic_button : pause_button;
            if (obs == lvl) begin
                n = k;
                break;
            end
        end
    endtask

    // One-cycle frame edge (n_int=1, n_int_next=0) followed by the low interrupt cycle.
    task automatic frame_edge();
        @(negedge clk28);
        n_int_next = 1'b0;
        @(negedge clk28);
        n_int      = 1'b0;
        n_int_next = 1'b1;
        @(negedge clk28);
        n_int      = 1'b1;
    endtask

    initial begin
        int n;
        int highs;
        int pulses;
        int first;

        rst_n       = 1'b0;
        n_magic_raw = 1'b1;
        n_pause_raw = 1'b1;
        n_int       = 1'b1;
        n_int_next  = 1'b1;

        // Reset state
        repeat (3) @(negedge clk28);
        check("reset_magic", int'(magic_button), 0);
        check("reset_pause", int'(pause_button), 0);
        check("reset_long",  int'(long_press),   0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk28);

        // 8-cycle glitch never survives three ticks of debounce
        n_magic_raw = 1'b0;
        highs = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk28);
            if (k == 8) n_magic_raw = 1'b1;
            if (magic_button) highs++;
        end
        check("glitch_magic_high_cycles", highs, 0);

        // Long press with no frame edge: rise, PENDING after release, drop at edge
        @(negedge clk28);
        n_magic_raw = 1'b0;
        wait_level(0, 1'b1, 30, n);
        check("magic_rise_in_window", int'(n >= 12 && n <= 16), 1);
        repeat (25) @(negedge clk28);
        n_magic_raw = 1'b1;
        repeat (25) @(negedge clk28);
        check("magic_pending_high", int'(magic_button), 1);
        n_int_next = 1'b0;
        @(posedge clk28);
        #1;
        check("magic_drop_after_edge", int'(magic_button), 0);
        @(negedge clk28);
        n_int      = 1'b0;
        n_int_next = 1'b1;
        @(negedge clk28);
        n_int      = 1'b1;

        // Pause held across a frame edge falls only after debounced release
        @(negedge clk28);
        n_pause_raw = 1'b0;
        wait_level(1, 1'b1, 30, n);
        check("pause_rise_in_window", int'(n >= 12 && n <= 16), 1);
        repeat (5) @(negedge clk28);
        frame_edge();
        check("pause_seen_after_edge", int'(pause_button), 1);
        repeat (3) @(negedge clk28);
        n_pause_raw = 1'b1;
        wait_level(1, 1'b0, 30, n);
        check("pause_fall_in_window", int'(n >= 12 && n <= 16), 1);

        // Simultaneous presses rise together
        @(negedge clk28);
        n_magic_raw = 1'b0;
        n_pause_raw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk28);
            #1;
            if (magic_button || pause_button) break;
        end
        check("both_magic_rise", int'(magic_button), 1);
        check("both_pause_rise", int'(pause_button), 1);
        repeat (3) @(negedge clk28);
        n_magic_raw = 1'b1;
        n_pause_raw = 1'b1;
        repeat (25) @(negedge clk28);
        frame_edge();
        check("both_magic_idle", int'(magic_button), 0);
        check("both_pause_idle", int'(pause_button), 0);

        // Long press: magic held for 60 cycles
        repeat (4) @(negedge clk28);
        n_magic_raw = 1'b0;
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk28);
            #1;
            if (long_press) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        @(negedge clk28);
        n_magic_raw = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk28);
            #1;
            if (long_press) pulses++;
        end
`ifdef LONG_PRESS_EN
        check("long_press_pulse_count", pulses, 1);
        check("long_press_in_window", int'(first >= 50 && first <= 56), 1);
`else
        check("long_press_pulse_count", pulses, 0);
`endif
        frame_edge();
        check("long_magic_idle", int'(magic_button), 0);

        // Reset while HELD discards the press; re-acceptance after a full debounce
        repeat (2) @(negedge clk28);
        n_magic_raw = 1'b0;
        wait_level(0, 1'b1, 30, n);
        check("held_before_reset", int'(magic_button), 1);
        @(negedge clk28);
        rst_n = 1'b0;
        @(posedge clk28);
        #1;
        check("reset_held_magic", int'(magic_button), 0);
        check("reset_held_pause", int'(pause_button), 0);
        check("reset_held_long",  int'(long_press),   0);
        @(negedge clk28);
        rst_n = 1'b1;
        wait_level(0, 1'b1, 30, n);
        check("reacquire_latency", n, 13);
        @(negedge clk28);
        n_magic_raw = 1'b1;
        repeat (5) @(negedge clk28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
